bip_control_unit: RTL and testbench

Multi-cycle control unit for the BIP processor. It fetches 16-bit instructions from program memory at the Program_Counter address, decodes them, and sequences the datapath enables: PC write, accumulator write, mux selects, ALU op, and data RAM read/write. It sits between program memory, Program_Counter, the accumulator/ALU datapath and data RAM. It also runs a clock-cycle counter for the top-level reporting logic.

---
 rtl/bip_pkg.sv | 43 ++++
 rtl/bip_decoder.sv | 56 +++++
 rtl/bip_control_unit.sv | 96 +++++++++
 tb/tb_bip_control_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared opcodes, state encoding and strobe bundle for the BIP control unit.
package bip_pkg;

    localparam int INSTR_W   = 16;
    localparam int OPCODE_W  = 5;
    localparam int OPERAND_W = 11;

    localparam logic [OPCODE_W-1:0] OP_HLT  = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_STO  = 5'd1;
    localparam logic [OPCODE_W-1:0] OP_LD   = 5'd2;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 5'd3;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd4;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 5'd5;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd6;
    localparam logic [OPCODE_W-1:0] OP_SUBI = 5'd7;

    localparam logic [1:0] SELA_RAM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic       wr_pc;
        logic       wr_acc;
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_ram;
        logic       rd_ram;
    } strobe_t;

    function automatic logic is_legal(input logic [OPCODE_W-1:0] opc);
        return opc <= OP_SUBI;
    endfunction

endpackage

// File: rtl/bip_decoder.sv
// Combinational strobe decode from opcode and current phase.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                in_decode,
    input  logic                in_exec,
    output strobe_t             strobes
);

    always_comb begin
        strobes = '0;
        if (in_decode) begin
            strobes.rd_ram = (opcode == OP_LD) ||
                             (opcode == OP_ADD) ||
                             (opcode == OP_SUB);
        end
        if (in_exec) begin
            // Undefined opcodes fall through as NOPs that still advance PC.
            strobes.wr_pc = (opcode != OP_HLT);
            unique case (opcode)
                OP_STO: strobes.wr_ram = 1'b1;
                OP_LD: begin
                    strobes.wr_acc = 1'b1;
                    strobes.sel_a  = SELA_RAM;
                end
                OP_LDI: begin
                    strobes.wr_acc = 1'b1;
                    strobes.sel_a  = SELA_IMM;
                end
                OP_ADD: begin
                    strobes.wr_acc = 1'b1;
                    strobes.sel_a  = SELA_ALU;
                end
                OP_ADDI: begin
                    strobes.wr_acc = 1'b1;
                    strobes.sel_a  = SELA_ALU;
                    strobes.sel_b  = 1'b1;
                end
                OP_SUB: begin
                    strobes.wr_acc = 1'b1;
                    strobes.sel_a  = SELA_ALU;
                    strobes.op     = 1'b1;
                end
                OP_SUBI: begin
                    strobes.wr_acc = 1'b1;
                    strobes.sel_a  = SELA_ALU;
                    strobes.sel_b  = 1'b1;
                    strobes.op     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bip_control_unit.sv
// BIP multi-cycle sequencer: FETCH/DECODE/EXEC with IR, sticky illegal
// flag and a saturating execution-cycle counter.
module bip_control_unit #(
    parameter int INSTR_W   = bip_pkg::INSTR_W,
    parameter int OPCODE_W  = bip_pkg::OPCODE_W,
    parameter int OPERAND_W = bip_pkg::OPERAND_W,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [INSTR_W-1:0]   instr_data,
    output logic                 WrPC,
    output logic                 WrAcc,
    output logic [1:0]           SelA,
    output logic                 SelB,
    output logic                 Op,
    output logic                 WrRam,
    output logic                 RdRam,
    output logic [OPERAND_W-1:0] operand,
    output logic                 halted,
    output logic                 illegal,
    output logic [CNT_W-1:0]     cycle_count
);

    import bip_pkg::*;

    state_t               state_q;
    logic [INSTR_W-1:0]   ir_q;
    logic                 illegal_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [OPCODE_W-1:0]  opcode;
    logic                 counting;
    strobe_t              stb;

    assign opcode   = ir_q[INSTR_W-1 -: OPCODE_W];
    assign counting = (state_q == ST_FETCH) ||
                      (state_q == ST_DECODE) ||
                      (state_q == ST_EXEC);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_FETCH;
                        cnt_q     <= '0;
                        illegal_q <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    ir_q    <= instr_data;
                    state_q <= ST_DECODE;
                end
                ST_DECODE: state_q <= ST_EXEC;
                ST_EXEC: begin
                    state_q <= (opcode == OP_HLT) ? ST_HALT : ST_FETCH;
                    if (!is_legal(opcode)) begin
                        illegal_q <= 1'b1;
                    end
                end
                ST_HALT: ;
                default: state_q <= ST_IDLE;
            endcase
            // Saturate rather than wrap so long runs still report a bound.
            if (counting && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    bip_decoder u_dec (
        .opcode    (opcode),
        .in_decode (state_q == ST_DECODE),
        .in_exec   (state_q == ST_EXEC),
        .strobes   (stb)
    );

    assign WrPC        = stb.wr_pc;
    assign WrAcc       = stb.wr_acc;
    assign SelA        = stb.sel_a;
    assign SelB        = stb.sel_b;
    assign Op          = stb.op;
    assign WrRam       = stb.wr_ram;
    assign RdRam       = stb.rd_ram;
    assign operand     = ir_q[OPERAND_W-1:0];
    assign halted      = (state_q == ST_HALT);
    assign illegal     = illegal_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// Directed bench for bip_control_unit with a per-instruction expectation model.
module tb_bip_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] instr_data;
    logic        WrPC, WrAcc, SelB, Op, WrRam, RdRam, halted, illegal;
    logic [1:0]  SelA;
    logic [10:0] operand;
    logic [15:0] cycle_count;

    always #5 clk = ~clk;

    bip_control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instr_data  (instr_data),
        .WrPC        (WrPC),
        .WrAcc       (WrAcc),
        .SelA        (SelA),
        .SelB        (SelB),
        .Op          (Op),
        .WrRam       (WrRam),
        .RdRam       (RdRam),
        .operand     (operand),
        .halted      (halted),
        .illegal     (illegal),
        .cycle_count (cycle_count)
    );

    typedef struct packed {
        logic        wrpc;
        logic        wracc;
        logic [1:0]  sela;
        logic        selb;
        logic        op;
        logic        wrram;
        logic        rdram;
        logic [10:0] operand;
        logic        halted;
        logic        illegal;
        logic [15:0] cnt;
    } obs_t;

    obs_t        exp_cur;
    obs_t        act;
    bit          exp_valid = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic [15:0] m_ir;
    bit          m_ill;
    bit          m_halt;
    int          m_cnt;

    always_comb act = {WrPC, WrAcc, SelA, SelB, Op, WrRam, RdRam,
                       operand, halted, illegal, cycle_count};

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (act !== exp_cur) begin
                errors++;
                $display("FAIL outputs t=%0t got %h want %h",
                         $time, act, exp_cur);
            end
        end
    end

    function automatic obs_t quiet();
        obs_t q;
        q         = '0;
        q.operand = m_ir[10:0];
        q.halted  = m_halt;
        q.illegal = m_ill;
        q.cnt     = m_cnt[15:0];
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bump();
        if (m_cnt < 65535) m_cnt++;
    endtask

    task automatic lit(input string name, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", name, a, e);
        end
    endtask

    task automatic model_clear();
        m_ir   = '0;
        m_cnt  = 0;
        m_ill  = 1'b0;
        m_halt = 1'b0;
    endtask

    task automatic do_reset(input bit with_start);
        exp_valid = 1'b0;
        reset     = 1'b1;
        start     = with_start;
        tick();
        reset     = 1'b0;
        start     = 1'b0;
        model_clear();
        exp_valid = 1'b1;
    endtask

    task automatic idle_cycles(input int n, input bit st);
        for (int i = 0; i < n; i++) begin
            start   = st;
            exp_cur = quiet();
            tick();
        end
        start = 1'b0;
    endtask

    task automatic do_start();
        start   = 1'b1;
        exp_cur = quiet();
        tick();
        start   = 1'b0;
        m_cnt   = 0;
        m_ill   = 1'b0;
    endtask

    task automatic run_instr(input logic [15:0] ins);
        int opc;
        opc        = int'(ins[15:11]);
        instr_data = ins;
        exp_cur    = quiet();
        tick();
        m_ir = ins;
        bump();
        instr_data    = 16'hA5A5;
        exp_cur       = quiet();
        exp_cur.rdram = (opc == 2) || (opc == 4) || (opc == 6);
        tick();
        bump();
        exp_cur       = quiet();
        exp_cur.wrpc  = (opc != 0);
        exp_cur.wrram = (opc == 1);
        exp_cur.wracc = (opc >= 2) && (opc <= 7);
        exp_cur.sela  = (opc == 3) ? 2'b01 :
                        ((opc >= 4) && (opc <= 7)) ? 2'b10 : 2'b00;
        exp_cur.selb  = (opc == 5) || (opc == 7);
        exp_cur.op    = (opc == 6) || (opc == 7);
        tick();
        bump();
        if (opc >= 8) m_ill = 1'b1;
        if (opc == 0) m_halt = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        instr_data = 16'h0000;
        model_clear();
        tick();
        do_reset(1'b0);
        idle_cycles(2, 1'b0);
        lit("rst_cnt", 32'(cycle_count), 32'h0);
        lit("rst_wrpc", 32'(WrPC), 32'h0);

        do_start();
        run_instr(16'h1805);
        lit("ldi_cnt", 32'(cycle_count), 32'd3);
        run_instr(16'h2010);
        lit("add_operand", 32'(operand), 32'h010);
        run_instr(16'hF800);
        lit("illegal_set", 32'(illegal), 32'h1);
        run_instr(16'h1802);
        lit("illegal_sticky", 32'(illegal), 32'h1);
        lit("cnt_4instr", 32'(cycle_count), 32'd12);

        do_reset(1'b0);
        idle_cycles(1, 1'b0);
        do_start();
        run_instr(16'h1801);
        run_instr(16'h3801);
        run_instr(16'h0FFF);
        run_instr(16'h0000);
        lit("hlt_halted", 32'(halted), 32'h1);
        lit("hlt_cnt", 32'(cycle_count), 32'd12);
        idle_cycles(4, 1'b1);
        lit("halt_hold_cnt", 32'(cycle_count), 32'd12);

        do_reset(1'b1);
        idle_cycles(3, 1'b0);
        lit("rst_beats_start", 32'(cycle_count), 32'h0);
        lit("rst_halted", 32'(halted), 32'h0);

        do_start();
        instr_data = 16'h2010;
        exp_cur    = quiet();
        tick();
        m_ir = 16'h2010;
        bump();
        instr_data    = 16'hA5A5;
        reset         = 1'b1;
        exp_cur       = quiet();
        exp_cur.rdram = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        idle_cycles(2, 1'b0);
        lit("mid_rst_rdram", 32'(RdRam), 32'h0);
        do_start();
        run_instr(16'h1807);
        lit("restart_cnt", 32'(cycle_count), 32'd3);

        do_reset(1'b0);
        do_start();
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        m_cnt = 16'hFFFE;
        run_instr(16'h1803);
        run_instr(16'h2804);
        lit("sat_cnt", 32'(cycle_count), 32'hFFFF);
        idle_cycles(1, 1'b0);

        exp_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
